// File: rtl/data_bus_responder_if.sv
// Data-side bus between the RV32I core and its responder: word-wide address, write strobe and data,
// with read data returned combinationally in the same cycle.
interface data_bus_responder_if;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] dataWData;
  logic [31:0] dataRData;

  modport master (output dataWe, dataAddr, dataWData, input dataRData);
  modport slave  (input dataWe, dataAddr, dataWData, output dataRData);
endinterface

// File: rtl/data_bus_responder.sv
// Core data-bus responder: word RAM plus GPO/GPI/compare-match timer MMIO block.
// Reads are zero-latency combinational, writes commit on the clock edge; the bus never stalls.
module data_bus_responder #(
  parameter int RAM_DEPTH = 64,
  parameter int GPO_W     = 8,
  parameter int GPI_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  output logic [GPO_W-1:0]     gpo,
  input  logic [GPI_W-1:0]     gpi,
  output logic                 timerIrq
);

  localparam int AW = $clog2(RAM_DEPTH);

  localparam logic [2:0] REG_GPO   = 3'd0;
  localparam logic [2:0] REG_GPI   = 3'd1;
  localparam logic [2:0] REG_TCNT  = 3'd2;
  localparam logic [2:0] REG_TCTRL = 3'd3;
  localparam logic [2:0] REG_TCMP  = 3'd4;
  localparam logic [2:0] REG_TSTAT = 3'd5;

  logic [31:0]      ram [RAM_DEPTH];
  logic [AW-1:0]    ram_idx;
  logic [2:0]       reg_sel;
  logic             ram_sel;
  logic             mmio_sel;
  logic             ram_we;
  logic             gpo_wr, tcnt_wr, tctrl_wr, tcmp_wr, tstat_wr;
  logic             match;

  logic [GPO_W-1:0] gpo_q;
  logic [GPI_W-1:0] gpi_meta, gpi_sync;
  logic [31:0]      tcnt, tcmp;
  logic             ten, tflag;

  // Upper offset bits alias and the byte lane bits are ignored on a word-only bus.
  logic unused_addr;
  assign unused_addr = ^{bus.dataAddr[27:AW+2], bus.dataAddr[1:0]};

  assign ram_idx  = bus.dataAddr[AW+1:2];
  assign reg_sel  = bus.dataAddr[4:2];
  assign ram_sel  = (bus.dataAddr[31:28] == 4'h1);
  assign mmio_sel = (bus.dataAddr[31:28] == 4'h2);

  assign ram_we   = bus.dataWe && ram_sel;
  assign gpo_wr   = bus.dataWe && mmio_sel && (reg_sel == REG_GPO);
  assign tcnt_wr  = bus.dataWe && mmio_sel && (reg_sel == REG_TCNT);
  assign tctrl_wr = bus.dataWe && mmio_sel && (reg_sel == REG_TCTRL);
  assign tcmp_wr  = bus.dataWe && mmio_sel && (reg_sel == REG_TCMP);
  assign tstat_wr = bus.dataWe && mmio_sel && (reg_sel == REG_TSTAT);

  // A software load of TCNT suppresses the match for that cycle.
  assign match = !tcnt_wr && ten && (tcnt == tcmp);

  // RAM is never cleared; reset only blocks a write from landing.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && ram_we) begin
      ram[ram_idx] <= bus.dataWData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpo_q    <= '0;
      gpi_meta <= '0;
      gpi_sync <= '0;
      tcnt     <= '0;
      ten      <= 1'b0;
      tcmp     <= 32'hFFFF_FFFF;
      tflag    <= 1'b0;
    end else begin
      gpi_meta <= gpi;
      gpi_sync <= gpi_meta;
      if (gpo_wr)   gpo_q <= bus.dataWData[GPO_W-1:0];
      if (tctrl_wr) ten   <= bus.dataWData[0];
      if (tcmp_wr)  tcmp  <= bus.dataWData;

      if (tcnt_wr)     tcnt <= bus.dataWData;
      else if (match)  tcnt <= '0;
      else if (ten)    tcnt <= tcnt + 32'd1;

      // Set beats a simultaneous write-one-to-clear.
      if (match)                              tflag <= 1'b1;
      else if (tstat_wr && bus.dataWData[0])  tflag <= 1'b0;
    end
  end

  always_comb begin
    bus.dataRData = '0;
    if (ram_sel) begin
      bus.dataRData = ram[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        REG_GPO:   bus.dataRData = 32'(gpo_q);
        REG_GPI:   bus.dataRData = 32'(gpi_sync);
        REG_TCNT:  bus.dataRData = tcnt;
        REG_TCTRL: bus.dataRData = {31'd0, ten};
        REG_TCMP:  bus.dataRData = tcmp;
        REG_TSTAT: bus.dataRData = {31'd0, tflag};
        default:   bus.dataRData = '0;
      endcase
    end
  end

  assign gpo      = gpo_q;
  assign timerIrq = tflag;

endmodule
